// File: rtl/mc_control_unit.sv
// CGRA run sequencer: optional context load, N kernel iterations under a watchdog, then interrupt.
// Decisions take effect one cycle after the inputs; no backpressure, pulses are single-cycle.
module mc_control_unit #(
    parameter int NUM_CTX = 4,
    parameter int ITER_W  = 16,
    parameter int TO_W    = 24,
    localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               start_i,
    input  logic [CTX_W-1:0]   ctx_sel_i,
    input  logic [ITER_W-1:0]  iters_i,
    input  logic [TO_W-1:0]    timeout_i,
    input  logic               abort_i,
    input  logic               conf_done_i,
    input  logic               inval_i,
    input  logic [CTX_W-1:0]   inval_ctx_i,
    input  logic               mn_done_i,
    output logic               conf_req_o,
    output logic [CTX_W-1:0]   conf_ctx_o,
    output logic               exec_o,
    output logic               clr_mn_o,
    output logic               clr_cgra_o,
    output logic               intr_o,
    output logic               err_o,
    output logic [NUM_CTX-1:0] ctx_valid_o,
    output logic [ITER_W-1:0]  iter_left_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONF = 3'd1,
        EXEC = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [CTX_W:0] NUM_CTX_L = (CTX_W + 1)'(NUM_CTX);

    state_t              state;
    logic [CTX_W-1:0]    ctx_q;
    logic [ITER_W-1:0]   iter_left;
    logic [TO_W-1:0]     to_q;
    logic [TO_W-1:0]     wdog;
    logic [NUM_CTX-1:0]  ctx_valid;
    logic                err_q;

    logic                conf_take;
    logic [CTX_W-1:0]    sel_c;
    logic [NUM_CTX-1:0]  valid_nxt;

    assign conf_take = (state == CONF) && conf_done_i && !abort_i;
    assign sel_c     = ({1'b0, ctx_sel_i} < NUM_CTX_L) ? ctx_sel_i : '0;

    // Invalidation is applied after the load so it wins on the same context.
    always_comb begin
        valid_nxt = ctx_valid;
        if (conf_take)
            valid_nxt[ctx_q] = 1'b1;
        if (inval_i && ({1'b0, inval_ctx_i} < NUM_CTX_L))
            valid_nxt[inval_ctx_i] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ctx_q     <= '0;
            iter_left <= '0;
            to_q      <= '0;
            wdog      <= '0;
            ctx_valid <= '0;
            err_q     <= 1'b0;
        end else if (clr_i) begin
            state     <= IDLE;
            ctx_q     <= '0;
            iter_left <= '0;
            to_q      <= '0;
            wdog      <= '0;
            ctx_valid <= '0;
            err_q     <= 1'b0;
        end else begin
            ctx_valid <= valid_nxt;
            wdog      <= '0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        ctx_q     <= sel_c;
                        iter_left <= (iters_i == '0) ? ITER_W'(1) : iters_i;
                        to_q      <= timeout_i;
                        err_q     <= 1'b0;
                        state     <= ctx_valid[sel_c] ? EXEC : CONF;
                    end
                end
                CONF: begin
                    if (abort_i) begin
                        state     <= ERR;
                        err_q     <= 1'b1;
                        iter_left <= '0;
                    end else if (conf_done_i) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (abort_i) begin
                        state     <= ERR;
                        err_q     <= 1'b1;
                        iter_left <= '0;
                    end else if (mn_done_i) begin
                        if (iter_left > ITER_W'(1)) begin
                            state <= NEXT;
                        end else begin
                            state     <= DONE;
                            iter_left <= '0;
                        end
                    end else if (to_q != '0 && wdog == to_q - TO_W'(1)) begin
                        state     <= ERR;
                        err_q     <= 1'b1;
                        iter_left <= '0;
                    end else begin
                        wdog <= wdog + TO_W'(1);
                    end
                end
                NEXT: begin
                    if (abort_i) begin
                        state     <= ERR;
                        err_q     <= 1'b1;
                        iter_left <= '0;
                    end else begin
                        iter_left <= iter_left - ITER_W'(1);
                        state     <= EXEC;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign conf_req_o  = (state == CONF);
    assign conf_ctx_o  = (state == CONF) ? ctx_q : '0;
    assign exec_o      = (state == EXEC);
    assign clr_mn_o    = (state == NEXT) || (state == DONE) || (state == ERR);
    assign clr_cgra_o  = (state == DONE) || (state == ERR) || (conf_take && !clr_i);
    assign intr_o      = (state == DONE) || (state == ERR);
    assign err_o       = err_q;
    assign ctx_valid_o = ctx_valid;
    assign iter_left_o = (state == CONF || state == EXEC || state == NEXT) ? iter_left : '0;
    assign state_o     = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_mc_control_unit;

    localparam int NUM_CTX = 4;
    localparam int ITER_W  = 16;
    localparam int TO_W    = 24;
    localparam int CTX_W   = 2;

    localparam int S_IDLE = 0, S_CONF = 1, S_EXEC = 2, S_NEXT = 3, S_DONE = 4, S_ERR = 5;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               clr_i;
    logic               start_i;
    logic [CTX_W-1:0]   ctx_sel_i;
    logic [ITER_W-1:0]  iters_i;
    logic [TO_W-1:0]    timeout_i;
    logic               abort_i;
    logic               conf_done_i;
    logic               inval_i;
    logic [CTX_W-1:0]   inval_ctx_i;
    logic               mn_done_i;
    logic               conf_req_o;
    logic [CTX_W-1:0]   conf_ctx_o;
    logic               exec_o;
    logic               clr_mn_o;
    logic               clr_cgra_o;
    logic               intr_o;
    logic               err_o;
    logic [NUM_CTX-1:0] ctx_valid_o;
    logic [ITER_W-1:0]  iter_left_o;
    logic [2:0]         state_o;

    mc_control_unit #(.NUM_CTX(NUM_CTX), .ITER_W(ITER_W), .TO_W(TO_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .start_i(start_i),
        .ctx_sel_i(ctx_sel_i), .iters_i(iters_i), .timeout_i(timeout_i),
        .abort_i(abort_i), .conf_done_i(conf_done_i), .inval_i(inval_i),
        .inval_ctx_i(inval_ctx_i), .mn_done_i(mn_done_i),
        .conf_req_o(conf_req_o), .conf_ctx_o(conf_ctx_o), .exec_o(exec_o),
        .clr_mn_o(clr_mn_o), .clr_cgra_o(clr_cgra_o), .intr_o(intr_o),
        .err_o(err_o), .ctx_valid_o(ctx_valid_o), .iter_left_o(iter_left_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase of the run, remaining iterations, cycles spent in the current iteration.
    int             m_st;
    int             m_ctx;
    int             m_iter;
    int             m_to;
    int             m_wd;
    bit [NUM_CTX-1:0] m_valid;
    bit             m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_ctx = 0; m_iter = 0; m_to = 0; m_wd = 0;
        m_valid = '0; m_err = 0;
    endtask

    function automatic bit conf_completes();
        return rst_ni && !clr_i && m_st == S_CONF && conf_done_i && !abort_i;
    endfunction

    task automatic model_step();
        int nxt;
        int c;
        bit [NUM_CTX-1:0] v;
        if (!rst_ni || clr_i) begin
            model_reset();
            return;
        end
        v = m_valid;
        if (conf_completes()) v[m_ctx] = 1'b1;
        if (inval_i && int'(inval_ctx_i) < NUM_CTX) v[inval_ctx_i] = 1'b0;
        nxt = m_st;
        if (abort_i && (m_st == S_CONF || m_st == S_EXEC || m_st == S_NEXT)) begin
            nxt = S_ERR;
        end else if (m_st == S_IDLE) begin
            if (start_i) begin
                c      = (int'(ctx_sel_i) < NUM_CTX) ? int'(ctx_sel_i) : 0;
                m_ctx  = c;
                m_iter = (iters_i == 0) ? 1 : int'(iters_i);
                m_to   = int'(timeout_i);
                m_err  = 0;
                nxt    = m_valid[c] ? S_EXEC : S_CONF;
            end
        end else if (m_st == S_CONF) begin
            if (conf_done_i) nxt = S_EXEC;
        end else if (m_st == S_EXEC) begin
            if (mn_done_i)                       nxt = (m_iter > 1) ? S_NEXT : S_DONE;
            else if (m_to != 0 && m_wd + 1 >= m_to) nxt = S_ERR;
        end else if (m_st == S_NEXT) begin
            m_iter = m_iter - 1;
            nxt    = S_EXEC;
        end else begin
            nxt = S_IDLE;
        end
        if (nxt == S_ERR)  begin m_err = 1; m_iter = 0; end
        if (nxt == S_DONE) m_iter = 0;
        m_wd    = (nxt == S_EXEC && m_st == S_EXEC) ? m_wd + 1 : 0;
        m_st    = nxt;
        m_valid = v;
    endtask

    task automatic check_all();
        bit fin;
        bit busy;
        fin  = (m_st == S_DONE || m_st == S_ERR);
        busy = (m_st == S_CONF || m_st == S_EXEC || m_st == S_NEXT);
        check("state",     state_o,     m_st);
        check("conf_req",  conf_req_o,  m_st == S_CONF);
        check("conf_ctx",  conf_ctx_o,  (m_st == S_CONF) ? m_ctx : 0);
        check("exec",      exec_o,      m_st == S_EXEC);
        check("clr_mn",    clr_mn_o,    fin || m_st == S_NEXT);
        check("clr_cgra",  clr_cgra_o,  fin || conf_completes());
        check("intr",      intr_o,      fin);
        check("err",       err_o,       m_err);
        check("ctx_valid", ctx_valid_o, m_valid);
        check("iter_left", iter_left_o, busy ? m_iter : 0);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1 check_all();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic quiet();
        clr_i = 0; start_i = 0; abort_i = 0; conf_done_i = 0; inval_i = 0; mn_done_i = 0;
    endtask

    task automatic launch(input int ctx, input int iters, input int to);
        start_i = 1; ctx_sel_i = CTX_W'(ctx); iters_i = ITER_W'(iters); timeout_i = TO_W'(to);
        tick();
        start_i = 0;
    endtask

    task automatic pulse_mn();
        mn_done_i = 1; tick(); mn_done_i = 0;
    endtask

    int intr_cnt;

    initial begin
        rst_ni = 0;
        quiet();
        ctx_sel_i = '0; iters_i = '0; timeout_i = '0; inval_ctx_i = '0;
        model_reset();
        tick();
        tick();
        rst_ni = 1;
        tick();

        // Cold start on context 2
        launch(2, 1, 0);
        check("cold_conf", state_o, S_CONF);
        repeat (4) tick();
        conf_done_i = 1; tick(); conf_done_i = 0;
        tick();
        pulse_mn();
        check("cold_done_intr", intr_o, 1);
        tick();
        check("cold_valid", ctx_valid_o, 4'b0100);

        // Warm restart, three iterations, exactly one interrupt
        launch(2, 3, 0);
        check("warm_exec", state_o, S_EXEC);
        intr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            mn_done_i = 1; tick(); mn_done_i = 0;
            if (intr_o) intr_cnt++;
            tick();
            if (intr_o) intr_cnt++;
        end
        check("warm_intr_count", intr_cnt, 1);

        // Watchdog expiry, then completion in the last allowed cycle
        launch(2, 1, 10);
        repeat (10) tick();
        check("wd_err_state", state_o, S_ERR);
        check("wd_err_flag", err_o, 1);
        tick();
        check("wd_err_sticky", err_o, 1);
        launch(2, 1, 10);
        repeat (9) tick();
        pulse_mn();
        check("wd_done_state", state_o, S_DONE);
        check("wd_done_err", err_o, 0);
        tick();

        // Abort in CONF, then abort with mn_done mid-EXEC; start ignored while running
        launch(3, 1, 0);
        abort_i = 1; tick(); abort_i = 0;
        check("abort_conf", state_o, S_ERR);
        tick();
        launch(2, 2, 0);
        start_i = 1; ctx_sel_i = 2'd1; tick(); start_i = 0;
        tick();
        abort_i = 1; mn_done_i = 1; tick(); abort_i = 0; mn_done_i = 0;
        check("abort_exec", state_o, S_ERR);
        tick();

        // Invalidate wins over a same-cycle load of the same context
        launch(1, 1, 0);
        conf_done_i = 1; inval_i = 1; inval_ctx_i = 2'd1; tick();
        conf_done_i = 0; inval_i = 0;
        check("inval_exec", state_o, S_EXEC);
        check("inval_bit", ctx_valid_o[1], 0);
        pulse_mn();
        tick();
        launch(1, 1, 0);
        check("inval_reconf", state_o, S_CONF);
        conf_done_i = 1; tick(); conf_done_i = 0;

        // Synchronous clear while executing
        clr_i = 1; tick(); clr_i = 0;
        check("clr_idle", state_o, S_IDLE);
        check("clr_no_intr", intr_o, 0);
        tick();

        // Asynchronous reset in the middle of NEXT
        launch(2, 2, 0);
        conf_done_i = 1; tick(); conf_done_i = 0;
        pulse_mn();
        check("pre_rst_next", state_o, S_NEXT);
        #2 rst_ni = 0;
        #1;
        check("arst_state", state_o, 0);
        check("arst_clr_mn", clr_mn_o, 0);
        check("arst_iter", iter_left_o, 0);
        model_reset();
        @(negedge clk_i);
        tick();
        rst_ni = 1;
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            start_i     = ($urandom_range(0, 3) == 0);
            ctx_sel_i   = CTX_W'($urandom_range(0, NUM_CTX - 1));
            iters_i     = ITER_W'($urandom_range(0, 4));
            timeout_i   = TO_W'($urandom_range(0, 12));
            conf_done_i = ($urandom_range(0, 3) == 0);
            mn_done_i   = ($urandom_range(0, 5) == 0);
            abort_i     = ($urandom_range(0, 39) == 0);
            inval_i     = ($urandom_range(0, 15) == 0);
            inval_ctx_i = CTX_W'($urandom_range(0, NUM_CTX - 1));
            clr_i       = ($urandom_range(0, 149) == 0);
            tick();
        end
        quiet();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter NUM_CTX, default 4: number of configuration contexts, legal range 1..16.
REQ-002 SHALL have parameter ITER_W, default 16: iteration-count width.
REQ-003 SHALL have parameter TO_W, default 24: watchdog-timeout width.
REQ-004 SHALL define CTX_W = max(1, clog2(NUM_CTX)).
REQ-005 SHALL have one clock and reset: clk_i in 1, rising edge; rst_ni in 1, asynchronous, active-low.
REQ-006 SHALL have port clr_i  in  1  synchronous clear; full reset equivalent, takes priority over all other inputs.
REQ-007 SHALL have port start_i  in  1  start request.
REQ-008 SHALL have port ctx_sel_i  in  CTX_W  context requested by start_i.
REQ-009 SHALL have port iters_i  in  ITER_W  kernel repetitions; 0 is treated as 1.
REQ-010 SHALL have port timeout_i  in  TO_W  max EXEC cycles per iteration; 0 disables the watchdog.
REQ-011 SHALL have port abort_i  in  1  cancel the run in progress.
REQ-012 SHALL have port conf_done_i  in  1  configuration load of the requested context finished.
REQ-013 SHALL have ports inval_i  in  1 and inval_ctx_i  in  CTX_W  mark that context unloaded.
REQ-014 SHALL have port mn_done_i  in  1  memory nodes finished one iteration.
REQ-015 SHALL have outputs:
- conf_req_o  out  1  configuration load requested
- conf_ctx_o  out  CTX_W  context to load
- exec_o  out  1  run active
- clr_mn_o  out  1  clear memory nodes
- clr_cgra_o  out  1  clear fabric
- intr_o  out  1  completion interrupt
- err_o  out  1  sticky error status
- ctx_valid_o  out  NUM_CTX  loaded-context bitmap
- iter_left_o  out  ITER_W  remaining iterations
- state_o  out  3  FSM state

Function
REQ-016 SHALL implement states IDLE=0, CONF=1, EXEC=2, NEXT=3, DONE=4, ERR=5; any other encoding SHALL return to IDLE next cycle.
REQ-017 start_i SHALL be accepted only in IDLE and ignored in all other states. Acceptance latches ctx_sel_i, max(iters_i,1) into iter_left, and timeout_i, and clears err_o.
REQ-018 On acceptance the FSM SHALL go to EXEC if ctx_valid[ctx_sel_i] is set, otherwise to CONF, on the next cycle.
REQ-019 In CONF: conf_req_o=1 and conf_ctx_o=latched ctx. conf_done_i SHALL set that context's ctx_valid bit, assert clr_cgra_o combinationally in the same cycle, and move the FSM to EXEC.
REQ-020 conf_done_i outside CONF SHALL be ignored.
REQ-021 In EXEC: exec_o=1 and a watchdog counts EXEC cycles from 0. On mn_done_i the FSM SHALL go to NEXT if iter_left>1, else to DONE.
REQ-022 If timeout_i!=0 and the watchdog equals timeout-1 with no mn_done_i, the FSM SHALL go to ERR. mn_done_i wins over timeout in the same cycle.
REQ-023 NEXT SHALL last one cycle: clr_mn_o=1, iter_left decrements by 1, the watchdog clears, then the FSM returns to EXEC.
REQ-024 DONE SHALL last one cycle: intr_o=clr_mn_o=clr_cgra_o=1, iter_left=0, then the FSM goes to IDLE.
REQ-025 ERR SHALL last one cycle: intr_o=clr_mn_o=clr_cgra_o=1, err_o set, iter_left=0, then the FSM goes to IDLE.
REQ-026 abort_i in CONF, EXEC or NEXT SHALL go to ERR on the next cycle. abort_i wins over mn_done_i, conf_done_i and timeout. abort_i in IDLE, DONE or ERR SHALL be ignored.
REQ-027 inval_i SHALL clear ctx_valid[inval_ctx_i] on the next cycle and wins over a same-cycle conf_done_i for the same context. The FSM SHALL still go to EXEC. An invalidation does not affect a run already in EXEC.
REQ-028 inval_ctx_i >= NUM_CTX SHALL be ignored; ctx_sel_i >= NUM_CTX SHALL be treated as context 0.
REQ-029 iter_left_o SHALL show the latched remaining count during CONF, EXEC and NEXT, and 0 otherwise.

Reset
REQ-030 rst_ni low or clr_i high SHALL set state=IDLE, ctx_valid=0, err_o=0, iter_left=0, watchdog=0.
REQ-031 Under reset all outputs SHALL be 0, including the combinational pulses, and conf_ctx_o=0.
REQ-032 Reset or clr_i mid-run SHALL drop the run with no intr_o.

Verification
REQ-033 Cold start: ctx_sel=2, iters=1, conf_done 5 cycles later -> CONF, with clr_cgra pulsing in the conf_done cycle; EXEC; mn_done -> DONE with a one-cycle intr and clr_mn; ctx_valid_o=4'b0100.
REQ-034 Warm restart: ctx 2 with iters=3 -> straight to EXEC with no conf_req; three mn_done -> NEXT twice, iter_left_o 3->2->1, one intr.
REQ-035 Watchdog: timeout=10 with no mn_done -> ERR exactly 10 EXEC cycles after entry; intr=1, err_o=1 until the next start. Also mn_done in cycle 10 -> DONE with err_o=0.
REQ-036 Abort: abort_i during CONF and again mid-EXEC together with mn_done -> ERR both times; start_i during EXEC is ignored.
REQ-037 Invalidate: inval ctx 1 in the same cycle as conf_done for ctx 1 -> EXEC but ctx_valid[1]=0; the next start on ctx 1 re-enters CONF.
REQ-038 Reset: clr_i in EXEC -> IDLE next cycle, all outputs 0, no intr; assert rst_ni asynchronously mid-NEXT -> outputs 0 immediately.
